// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx between N_REQ byte sources.
// Optional frame watchdog is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int START_HOLD = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         ack,
    output logic [7:0]               txpd,
    output logic                     tstart,
    input  logic                     tx_busy,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     err
);
    localparam int IDW = $clog2(N_REQ);
    localparam int IW1 = IDW + 1;
    localparam int HW  = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    if (N_REQ < 2 || N_REQ > 8 || START_HOLD < 1 || TIMEOUT < 1 || TIMEOUT > 65536) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] ptr_next;
    logic [IW1-1:0] idx;
    logic [HW-1:0]  hold;

    // Scan offsets from the far end down, so the requester closest to ptr wins.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + IW1'(k);
            if (idx >= IW1'(N_REQ)) idx = idx - IW1'(N_REQ);
            if (req[idx[IDW-1:0]]) win = idx[IDW-1:0];
        end
    end

    assign ptr_next = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] wd;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ack      <= '0;
            txpd     <= '0;
            tstart   <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
            ptr      <= '0;
            hold     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            wd       <= '0;
            err      <= 1'b0;
`endif
        end else begin
            ack <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        txpd     <= req_data[{win, 3'b000} +: 8];
                        grant_id <= win;
                        ack      <= N_REQ'(1) << win;
                        tstart   <= 1'b1;
                        busy     <= 1'b1;
                        hold     <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (hold == HW'(START_HOLD - 1)) begin
                        tstart <= 1'b0;
                        state  <= tx_busy ? S_WAIT_DONE : S_WAIT_BUSY;
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        ptr   <= ptr_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef UART_ARB_TIMEOUT_EN
            // Watchdog restarts while strobing, so it measures only the wait for the frame.
            if (state == S_START) begin
                wd <= '0;
            end else if (state == S_WAIT_BUSY || state == S_WAIT_DONE) begin
                wd <= wd + 16'd1;
                if (wd == 16'(TIMEOUT - 1)) begin
                    err   <= 1'b1;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    ptr   <= ptr_next;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural uart_tx busy stub.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int SH = 2;
    localparam int TO = 64;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TE = 1'b1;
`else
    localparam bit TE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, tx_busy, tstart, busy, err;
    logic [N-1:0] req, ack;
    logic [8*N-1:0] req_data;
    logic [7:0] txpd;
    logic [$clog2(N)-1:0] grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .START_HOLD(SH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .txpd(txpd),
        .tstart(tstart), .tx_busy(tx_busy), .busy(busy), .grant_id(grant_id), .err(err)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    bit m_act = 0, m_seen = 0, m_err = 0, m_ts = 0, m_chk_txpd = 0;
    int m_ptr = 0, m_gid = 0, m_g = 0;
    logic [7:0] m_txpd = '0;
    logic [N-1:0] m_ack = '0;

    // uart_tx stub and observation records
    bit auto_busy = 0, prev_ts = 0, prev_busy = 0;
    int ub_on = 0, ub_off = 0, d_lo = 1, d_hi = 5, f_lo = 2, f_hi = 12;
    int tb_fall_cyc = 0, busy_fall_cyc = 0, ts_cycles = 0, ack_cycles = 0;
    int grants[$];
    logic [7:0] bytes[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic step();
        logic [N-1:0] r;
        logic [8*N-1:0] d;
        logic tb, rs, nb;
        int w, k;
        r = req; d = req_data; tb = tx_busy; rs = rst;
        @(posedge clk);
        cyc++;
        m_ack = '0;
        if (rs) begin
            m_act = 0; m_ptr = 0; m_gid = 0; m_txpd = '0; m_err = 0;
        end else if (!m_act) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_act = 1; m_g = cyc; m_seen = 0; m_gid = w;
                m_txpd = d[8*w +: 8];
                m_ack[w] = 1'b1;
            end
        end else begin
            k = cyc - m_g;
            if (TE && k == SH + TO) begin
                m_err = 1; m_act = 0; m_ptr = (m_gid + 1) % N;
            end else if (k >= SH) begin
                if (m_seen && !tb) begin
                    m_act = 0; m_ptr = (m_gid + 1) % N;
                end else if (tb) begin
                    m_seen = 1;
                end
            end
        end
        m_ts = m_act && (cyc - m_g) < SH;
        m_chk_txpd = m_act || rs;
        #1;
        chk("ack", ack, m_ack);
        chk("tstart", tstart, m_ts);
        chk("busy", busy, m_act);
        chk("grant_id", grant_id, m_gid);
        chk("err", err, m_err);
        if (m_chk_txpd) chk("txpd", txpd, m_txpd);
        if (ack !== '0) begin
            grants.push_back(int'(grant_id));
            bytes.push_back(txpd);
            ack_cycles++;
        end
        if (tstart === 1'b1) ts_cycles++;
        if (prev_busy && busy === 1'b0) busy_fall_cyc = cyc;
        prev_busy = (busy === 1'b1);
        if (tstart === 1'b1 && !prev_ts) begin
            ub_on  = cyc + int'($urandom_range(d_hi, d_lo));
            ub_off = ub_on + int'($urandom_range(f_hi, f_lo));
        end
        prev_ts = (tstart === 1'b1);
        if (auto_busy) begin
            nb = (cyc >= ub_on && cyc < ub_off);
            if (tx_busy === 1'b1 && !nb) tb_fall_cyc = cyc;
            tx_busy = nb;
        end
    endtask

    task automatic run_until_idle(string tag, int maxc);
        int c = 0;
        do begin step(); c++; end while ((m_act || busy !== 1'b0) && c < maxc);
        chk(tag, c < maxc, 1);
    endtask

    task automatic wait_in_frame(string tag, int maxc);
        int c = 0;
        while (!(tx_busy === 1'b1 && tstart === 1'b0 && busy === 1'b1) && c < maxc) begin
            step(); c++;
        end
        chk(tag, c < maxc, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c, g, ack_cyc;
        rst = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
        step(); step();
        rst = 1'b0;

        // random activity, then a one-cycle reset in the middle of it
        auto_busy = 1;
        for (int i = 0; i < 40; i++) begin
            req = N'($urandom); req_data = {$urandom}; step();
        end
        rst = 1'b1; step(); rst = 1'b0; req = '0;
        chk("t1_ack", ack, 0); chk("t1_tstart", tstart, 0); chk("t1_busy", busy, 0);
        chk("t1_txpd", txpd, 0); chk("t1_gid", grant_id, 0); chk("t1_err", err, 0);
        tx_busy = 1'b0; ub_on = 0; ub_off = 0;
        step(); step();

        // single requester, busy appears 4 cycles after tstart and lasts 20
        d_lo = 4; d_hi = 4; f_lo = 20; f_hi = 20;
        ts_cycles = 0; ack_cycles = 0; grants.delete(); bytes.delete();
        req = 4'b0001; req_data[7:0] = 8'h3A;
        step(); req = '0;
        run_until_idle("t2_done", 100);
        chk("t2_acks", ack_cycles, 1); chk("t2_tstart_cycles", ts_cycles, 2);
        chk("t2_byte", bytes[0], 8'h3A);
        chk("t2_busy_fall_gap", busy_fall_cyc - tb_fall_cyc, 1);

        // all four held: strict round-robin rotation
        d_lo = 1; d_hi = 5; f_lo = 2; f_hi = 12;
        do_reset();
        grants.delete(); bytes.delete();
        req_data = {8'h55, 8'h8F, 8'hFF, 8'h3A}; req = 4'b1111;
        c = 0;
        while (grants.size() < 5 && c < 500) begin step(); c++; end
        chk("t3_progress", c < 500, 1);
        req = '0;
        run_until_idle("t3_done", 100);
        if (grants.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                logic [7:0] exp_b;
                logic [31:0] expv;
                expv = {8'h55, 8'h8F, 8'hFF, 8'h3A};
                exp_b = expv[8*(i % 4) +: 8];
                chk("t3_grant", grants[i], i % 4);
                chk("t3_byte", bytes[i], exp_b);
            end
        end

        // request raised mid-frame waits until tx_busy falls
        do_reset();
        d_lo = 2; d_hi = 2; f_lo = 8; f_hi = 8;
        req = 4'b0001; req_data = {$urandom};
        step(); req = '0;
        wait_in_frame("t4_in_frame", 50);
        req = 4'b0100; req_data[23:16] = 8'hC4;
        c = 0; ack_cyc = 0;
        while (ack === '0 && c < 200) begin step(); c++; end
        chk("t4_ack_seen", c < 200, 1);
        ack_cyc = cyc;
        chk("t4_gap", ack_cyc - tb_fall_cyc, 2);
        chk("t4_gid", grant_id, 2); chk("t4_byte", txpd, 8'hC4);
        req = '0;
        run_until_idle("t4_done", 100);

        // reset during WAIT_DONE, pending req[1] served once afterwards
        do_reset();
        d_lo = 1; d_hi = 1; f_lo = 10; f_hi = 10;
        req = 4'b0001;
        step(); req = '0;
        wait_in_frame("t5_in_frame", 50);
        step();
        req = 4'b0010; rst = 1'b1; step(); rst = 1'b0;
        chk("t5_busy", busy, 0); chk("t5_gid", grant_id, 0);
        ack_cycles = 0;
        step(); req = '0;
        chk("t5_ack", ack, 4'b0010);
        run_until_idle("t5_done", 100);
        chk("t5_ack_count", ack_cycles, 1);

        // transmitter never reports busy
        do_reset();
        auto_busy = 0; tx_busy = 1'b0;
        req = 4'b0001;
        step(); g = cyc;
`ifdef UART_ARB_TIMEOUT_EN
        req = 4'b1000;
        c = 0;
        while (err !== 1'b1 && c < 300) begin step(); c++; end
        chk("t6_err_seen", c < 300, 1);
        chk("t6_err_delay", cyc - (g + SH), TO);
        c = 0;
        while (ack === '0 && c < 20) begin step(); c++; end
        chk("t6_next_ack", c < 20, 1);
        chk("t6_next_gid", grant_id, 3);
        req = '0;
        for (int i = 0; i < 80; i++) step();
        chk("t6_sticky", err, 1);
        do_reset();
        chk("t6_err_cleared", err, 0);
`else
        req = '0;
        for (int i = 0; i < 150; i++) step();
        chk("t6_still_busy", busy, 1);
        chk("t6_err_zero", err, 0);
        do_reset();
`endif

        // randomized traffic with occasional resets
        auto_busy = 1; tx_busy = 1'b0; ub_on = 0; ub_off = 0;
        d_lo = 1; d_hi = 5; f_lo = 2; f_hi = 12;
        grants.delete(); bytes.delete();
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7, 0) == 0) req[b] = ~req[b];
            req_data = {$urandom};
            rst = ($urandom_range(399, 0) == 0);
            step();
        end
        rst = 1'b0;
        chk("rand_progress", grants.size() > 50, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
